// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width (never narrower than 1 bit).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_ctrl_fs_cell.sv
// One-bit full subtractor: d = x - y - c, bo = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (y & c) | (~x & c);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin: one full-subtractor cell stepped LSB first, one bit per clock.
module serial_subtractor_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_ctrl_if.slave  bus
);
    localparam int unsigned      CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic             ready_d;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_d;
    logic             cell_bo;
    logic             load;
    logic             step;
    logic             last;

    assign load = (state_q == IDLE) && bus.start;
    assign step = (state_q == RUN);
    assign last = step && (cnt_q == LAST);

    // State register; handshake outputs are registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus.ready <= ready_d;
            bus.busy  <= busy_d;
            bus.done  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they line up with state_q.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            IDLE:    ready_d = 1'b1;
            RUN:     busy_d  = 1'b1;
            DONE:    done_d  = 1'b1;
            default: ready_d = 1'b1;
        endcase
    end

    fs_cell u_cell (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .c  (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Operand/result shift registers, running borrow and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
        end else if (load) begin
            sh_a     <= bus.a;
            sh_b     <= bus.b;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
        end else if (step) begin
            sh_a     <= sh_a >> 1;
            sh_b     <= sh_b >> 1;
            borrow_q <= cell_bo;
            cnt_q    <= cnt_q + CNT_W'(1);
            bus.diff <= {cell_d, bus.diff[WIDTH-1:1]};
            if (last) begin
                bus.bout <= cell_bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8 and exhaustive WIDTH=4.
module tb_serial_subtractor_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready8();
        for (int i = 0; i < 30 && !bus8.ready; i++) @(negedge clk);
    endtask

    // One WIDTH=8 transaction with latency, busy-length and hold checks.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb);
        int  busy_n;
        bit  got_done;
        @(negedge clk);
        wait_ready8();
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.bin   = ~bin;
        busy_n   = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus8.busy) busy_n++;
            @(posedge clk); #1;
        end
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus8.bout), 32'(eb));
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
        check({tag, "_ready_back"}, 32'(bus8.ready), 32'd1);
        check({tag, "_diff_hold"}, 32'(bus8.diff), 32'(ed));
    endtask

    initial begin
        logic [8:0]  t9;
        logic [4:0]  t5;
        logic [8:0]  expq[$];
        logic [8:0]  e9;
        int          last_done;
        int          n_done;
        bit          got_done;
        logic [3:0]  av;
        logic [3:0]  bv;
        logic        cv;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(bus8.ready), 32'd1);
        check("rst_busy",  32'(bus8.busy),  32'd0);
        check("rst_done",  32'(bus8.done),  32'd0);
        check("rst_diff",  32'(bus8.diff),  32'd0);
        check("rst_bout",  32'(bus8.bout),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op8("t1_5m3",     8'd5,    8'd3,    1'b0, 8'h02, 1'b0);
        op8("t2_0m1",     8'h00,   8'h01,   1'b0, 8'hFF, 1'b1);
        op8("t2_80m7f",   8'h80,   8'h7F,   1'b1, 8'h00, 1'b0);
        op8("t3_ripple",  8'h00,   8'hFF,   1'b1, 8'h00, 1'b1);
        op8("t2_eq",      8'hA5,   8'hA5,   1'b0, 8'h00, 1'b0);

        // start held high with operands changing every cycle
        @(negedge clk);
        wait_ready8();
        last_done = -1;
        n_done    = 0;
        for (int c = 0; c < 45; c++) begin
            bus8.a     = 8'(c * 37 + 5);
            bus8.b     = 8'(c * 53 + 2);
            bus8.bin   = c[0];
            bus8.start = 1'b1;
            if (bus8.ready) begin
                t9 = {1'b0, bus8.a} - {1'b0, bus8.b} - 9'(bus8.bin);
                expq.push_back(t9);
            end
            @(posedge clk); #1;
            if (bus8.done) begin
                n_done++;
                if (last_done >= 0) check("t4_gap", 32'(c - last_done), 32'd10);
                last_done = c;
                if (expq.size() == 0) begin
                    check("t4_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e9 = expq.pop_front();
                    check("t4_diff", 32'(bus8.diff), 32'(e9[7:0]));
                    check("t4_bout", 32'(bus8.bout), 32'(e9[8]));
                end
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check("t4_done_count", 32'(n_done), 32'd4);
        repeat (12) @(posedge clk);

        // reset mid-RUN after E3, with a live borrow inside the datapath
        @(negedge clk);
        wait_ready8();
        bus8.a = 8'h00; bus8.b = 8'h01; bus8.bin = 1'b1; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_ready", 32'(bus8.ready), 32'd1);
        check("t5_busy",  32'(bus8.busy),  32'd0);
        check("t5_done",  32'(bus8.done),  32'd0);
        check("t5_diff",  32'(bus8.diff),  32'd0);
        check("t5_bout",  32'(bus8.bout),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8("t5_9m4", 8'd9, 8'd4, 1'b0, 8'd5, 1'b0);

        // WIDTH=4 exhaustive against the arithmetic reference
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int z = 0; z < 2; z++) begin
                    av = 4'(x); bv = 4'(y); cv = 1'(z);
                    @(negedge clk);
                    for (int i = 0; i < 20 && !bus4.ready; i++) @(negedge clk);
                    bus4.a = av; bus4.b = bv; bus4.bin = cv; bus4.start = 1'b1;
                    @(posedge clk); #1;
                    bus4.start = 1'b0;
                    got_done = 1'b0;
                    for (int i = 0; i < 20; i++) begin
                        if (bus4.done) begin
                            got_done = 1'b1;
                            break;
                        end
                        @(posedge clk); #1;
                    end
                    t5 = {1'b0, av} - {1'b0, bv} - 5'(cv);
                    if (!got_done) check("t6_done", 32'd0, 32'd1);
                    check("t6_diff", 32'(bus4.diff), 32'(t5[3:0]));
                    check("t6_bout", 32'(bus4.bout), 32'(t5[4]));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
